// File: rtl/compress_pkg.sv
// Shared types and widths for the compressor front-end sequencer.
// A cache line is always exactly two pipeline words.
package compress_pkg;

  localparam int WIDTH      = 64;
  localparam int CACHE_LINE = 2 * WIDTH;
  localparam int TIMER_W    = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FEED0  = 3'd1,
    FEED1  = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// One increment per cycle when i_inc is high; async active-low clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/compress_line_sequencer.sv
// Splits each accepted cache line into two pipeline words, waits for done/stop (or a drain
// timeout) and posts one registered result per line; keeps saturating line statistics.
module compress_line_sequencer
  import compress_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int          CNT_W   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_line_valid,
  input  logic [CACHE_LINE-1:0] i_line,
  output logic                  o_line_ready,
  output logic [WIDTH-1:0]      o_word,
  output logic                  o_word_valid,
  input  logic                  i_stop_flag,
  input  logic                  i_done_flag,
  output logic                  o_res_valid,
  output logic                  o_res_bypass,
  output logic                  o_res_error,
  input  logic                  i_res_ready,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_cnt_compressed,
  output logic [CNT_W-1:0]      o_cnt_bypassed
);

  seq_state_t         r_state;
  seq_state_t         w_nxt_state;

  logic [WIDTH-1:0]   r_line_hi;
  logic               r_bypass;
  logic [TIMER_W-1:0] r_timer;

  logic               r_line_ready;
  logic               r_busy;
  logic               r_word_valid;
  logic [WIDTH-1:0]   r_word;
  logic               r_res_valid;
  logic               r_res_bypass;
  logic               r_res_error;

  logic               w_nxt_line_ready;
  logic               w_nxt_busy;
  logic               w_nxt_word_valid;
  logic [WIDTH-1:0]   w_nxt_word;
  logic               w_nxt_res_valid;
  logic               w_nxt_res_bypass;
  logic               w_nxt_res_error;

  logic               w_accept;
  logic               w_flag;
  logic               w_timeout;
  logic               w_res_hs;

  assign w_accept  = (r_state == IDLE) && i_line_valid;
  assign w_flag    = i_done_flag || i_stop_flag;
  assign w_timeout = (r_state == DRAIN) && !w_flag && (r_timer == TIMER_W'(TIMEOUT));
  assign w_res_hs  = (r_state == RESULT) && i_res_ready;

  // State plus all outputs are registered on the same edge so they always agree.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_line_ready <= 1'b1;
      r_busy       <= 1'b0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
      r_res_valid  <= 1'b0;
      r_res_bypass <= 1'b0;
      r_res_error  <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_line_ready <= w_nxt_line_ready;
      r_busy       <= w_nxt_busy;
      r_word_valid <= w_nxt_word_valid;
      r_word       <= w_nxt_word;
      r_res_valid  <= w_nxt_res_valid;
      r_res_bypass <= w_nxt_res_bypass;
      r_res_error  <= w_nxt_res_error;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      IDLE:    if (i_line_valid) w_nxt_state = FEED0;
      FEED0:   w_nxt_state = FEED1;
      FEED1:   w_nxt_state = DRAIN;
      DRAIN:   if (w_flag || w_timeout) w_nxt_state = RESULT;
      RESULT:  if (i_res_ready) w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  // Low word comes straight from i_line: it is driven on the cycle after acceptance.
  always_comb begin
    w_nxt_line_ready = (w_nxt_state == IDLE);
    w_nxt_busy       = (w_nxt_state != IDLE);
    w_nxt_word_valid = 1'b0;
    w_nxt_word       = '0;
    w_nxt_res_valid  = 1'b0;
    w_nxt_res_bypass = 1'b0;
    w_nxt_res_error  = 1'b0;
    case (w_nxt_state)
      FEED0: begin
        w_nxt_word_valid = 1'b1;
        w_nxt_word       = i_line[WIDTH-1:0];
      end
      FEED1: begin
        w_nxt_word_valid = 1'b1;
        w_nxt_word       = r_line_hi;
      end
      RESULT: begin
        w_nxt_res_valid = 1'b1;
        if (r_state == RESULT) begin
          w_nxt_res_bypass = r_res_bypass;
          w_nxt_res_error  = r_res_error;
        end else begin
          w_nxt_res_bypass = r_bypass || i_stop_flag || w_timeout;
          w_nxt_res_error  = w_timeout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_line_hi <= '0;
      r_bypass  <= 1'b0;
      r_timer   <= '0;
    end else begin
      if (w_accept) begin
        r_line_hi <= i_line[CACHE_LINE-1:WIDTH];
        r_bypass  <= 1'b0;
      end else if (((r_state == FEED1) || (r_state == DRAIN)) && i_stop_flag) begin
        r_bypass  <= 1'b1;
      end
      if (r_state == FEED1) begin
        r_timer <= '0;
      end else if (r_state == DRAIN) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_compressed (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_res_hs && !r_res_bypass),
    .o_count (o_cnt_compressed)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_bypassed (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_res_hs && r_res_bypass && !r_res_error),
    .o_count (o_cnt_bypassed)
  );

  assign o_line_ready = r_line_ready;
  assign o_busy       = r_busy;
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;
  assign o_res_valid  = r_res_valid;
  assign o_res_bypass = r_res_bypass;
  assign o_res_error  = r_res_error;

endmodule
